// File: rtl/mcc_pkg.sv
// Shared constants and the per-channel next-state record for the counter bank.
package mcc_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Widest channel the next-state record can carry; channels use the low CW bits.
  localparam int MCC_CNT_MAX = 32;

  typedef struct packed {
    logic [MCC_CNT_MAX-1:0] cnt;
    logic                   tc;
    logic                   wrap;
  } mcc_nxt_t;

endpackage

// File: rtl/mcc_channel.sv
// One up/down counter with limit, wrap/saturate mode, load, terminal-count pulse
// and sticky wrap flag.
module mcc_channel
  import mcc_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          step_i,
  input  logic          dir_i,
  input  logic          sat_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic [CW-1:0] limit_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o,
  output logic          wrap_flg_o
);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   tc_q;
  logic                   wrap_q, wrap_d;
  logic [MCC_CNT_MAX-1:0] cnt_x, lim_x, ldv_x;
  mcc_nxt_t               nxt;

  assign cnt_x = MCC_CNT_MAX'(cnt_q);
  assign lim_x = MCC_CNT_MAX'(limit_i);
  assign ldv_x = MCC_CNT_MAX'(load_val_i);

  always_comb begin
    nxt.cnt  = cnt_x;
    nxt.tc   = 1'b0;
    nxt.wrap = 1'b0;
    if (load_i) begin
      nxt.cnt = (ldv_x > lim_x) ? lim_x : ldv_x;
    end else if (step_i) begin
      if (dir_i == DIR_UP) begin
        if (cnt_x < lim_x) begin
          nxt.cnt = cnt_x + 1'b1;
        end else begin
          nxt.tc = 1'b1;
          if (sat_i == MODE_SAT) begin
            nxt.cnt = lim_x;
          end else begin
            nxt.cnt  = '0;
            nxt.wrap = 1'b1;
          end
        end
      end else if (dir_i == DIR_DN) begin
        // A count left above a freshly lowered limit snaps back without a pulse.
        if (cnt_x > lim_x) begin
          nxt.cnt = lim_x;
        end else if (cnt_x != '0) begin
          nxt.cnt = cnt_x - 1'b1;
        end else begin
          nxt.tc = 1'b1;
          if (sat_i == MODE_WRAP) begin
            nxt.cnt  = lim_x;
            nxt.wrap = 1'b1;
          end else begin
            nxt.cnt = '0;
          end
        end
      end
    end
  end

  assign cnt_d  = nxt.cnt[CW-1:0];
  assign wrap_d = nxt.wrap | (wrap_q & ~clr_i);

  generate
    if (CW < MCC_CNT_MAX) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^nxt.cnt[MCC_CNT_MAX-1:CW];
    end
  endgenerate

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tc_q   <= nxt.tc;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign tc_o       = tc_q;
  assign wrap_flg_o = wrap_q;

endmodule

// File: rtl/multi_channel_counter.sv
// Bank of NCH independent up/down counters sharing one count tick.
// Define MCC_PRESCALE_EN to add the shared prescaler and its psc_div port.
module multi_channel_counter
  import mcc_pkg::*;
#(
  parameter int CW  = 8,
  parameter int NCH = 2,
  parameter int PSW = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH-1:0]    en,
  input  logic [NCH-1:0]    dir,
  input  logic [NCH-1:0]    sat,
  input  logic [NCH-1:0]    load,
  input  logic [NCH*CW-1:0] load_val,
  input  logic [NCH*CW-1:0] limit,
  input  logic [NCH-1:0]    clr,
`ifdef MCC_PRESCALE_EN
  input  logic [PSW-1:0]    psc_div,
`endif
  output logic [NCH*CW-1:0] c_out,
  output logic [NCH-1:0]    tc,
  output logic [NCH-1:0]    wrap_flg
);

  logic tick;

`ifdef MCC_PRESCALE_EN
  logic [PSW-1:0] psc_q, psc_d;

  // psc_div is compared live, so a change takes effect on the very next match.
  assign tick  = (psc_q == psc_div);
  assign psc_d = tick ? '0 : psc_q + 1'b1;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end
`else
  logic [PSW-1:0] unused_psc;
  assign unused_psc = '0;
  assign tick       = 1'b1;
`endif

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : gen_ch
      mcc_channel #(
        .CW(CW)
      ) u_ch (
        .clk       (clk),
        .resetn    (resetn),
        .step_i    (en[gi] & tick),
        .dir_i     (dir[gi]),
        .sat_i     (sat[gi]),
        .load_i    (load[gi]),
        .load_val_i(load_val[gi*CW +: CW]),
        .limit_i   (limit[gi*CW +: CW]),
        .clr_i     (clr[gi]),
        .cnt_o     (c_out[gi*CW +: CW]),
        .tc_o      (tc[gi]),
        .wrap_flg_o(wrap_flg[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_channel_counter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_multi_channel_counter;
  localparam int CW  = 8;
  localparam int NCH = 2;
  localparam int PSW = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NCH-1:0]    en, dir, sat, load, clr;
  logic [NCH*CW-1:0] load_val, limit;
`ifdef MCC_PRESCALE_EN
  logic [PSW-1:0]    psc_div;
`endif
  logic [NCH*CW-1:0] c_out;
  logic [NCH-1:0]    tc, wrap_flg;

  always #5 clk = ~clk;

  multi_channel_counter #(.CW(CW), .NCH(NCH), .PSW(PSW)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .en      (en),
    .dir     (dir),
    .sat     (sat),
    .load    (load),
    .load_val(load_val),
    .limit   (limit),
    .clr     (clr),
`ifdef MCC_PRESCALE_EN
    .psc_div (psc_div),
`endif
    .c_out   (c_out),
    .tc      (tc),
    .wrap_flg(wrap_flg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: integer count per channel, rules applied directly.
  int m_cnt[NCH];
  int m_tc[NCH];
  int m_wf[NCH];
`ifdef MCC_PRESCALE_EN
  int m_psc;
`endif

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0;
      m_tc[c]  = 0;
      m_wf[c]  = 0;
    end
`ifdef MCC_PRESCALE_EN
    m_psc = 0;
`endif
  endfunction

  function automatic void model_edge();
    int tk, lv, lim, set;
    if (resetn) begin
      model_reset();
      return;
    end
`ifdef MCC_PRESCALE_EN
    tk    = (m_psc == int'(psc_div)) ? 1 : 0;
    m_psc = tk ? 0 : (m_psc + 1) % (1 << PSW);
`else
    tk = 1;
`endif
    for (int c = 0; c < NCH; c++) begin
      lv      = int'(load_val[c*CW +: CW]);
      lim     = int'(limit[c*CW +: CW]);
      set     = 0;
      m_tc[c] = 0;
      if (load[c]) begin
        m_cnt[c] = (lv < lim) ? lv : lim;
      end else if (en[c] && tk == 1) begin
        if (dir[c]) begin
          if (m_cnt[c] < lim) m_cnt[c] = m_cnt[c] + 1;
          else begin
            m_tc[c] = 1;
            if (sat[c]) m_cnt[c] = lim;
            else begin m_cnt[c] = 0; set = 1; end
          end
        end else begin
          if (m_cnt[c] > lim) m_cnt[c] = lim;
          else if (m_cnt[c] > 0) m_cnt[c] = m_cnt[c] - 1;
          else begin
            m_tc[c] = 1;
            if (sat[c]) m_cnt[c] = 0;
            else begin m_cnt[c] = lim; set = 1; end
          end
        end
      end
      m_wf[c] = set ? 1 : (clr[c] ? 0 : m_wf[c]);
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("c_out[%0d]", c), 32'(c_out[c*CW +: CW]), m_cnt[c]);
      check($sformatf("tc[%0d]", c), 32'(tc[c]), m_tc[c]);
      check($sformatf("wrap_flg[%0d]", c), 32'(wrap_flg[c]), m_wf[c]);
    end
  endtask

  task automatic mid_reset(input string tag);
    @(posedge clk);
    model_edge();
    #3;
    resetn = 1'b1;
    #1;
    check({tag, "_c_out"}, 32'(c_out), 0);
    check({tag, "_tc"}, 32'(tc), 0);
    check({tag, "_wrap"}, 32'(wrap_flg), 0);
    model_reset();
    cycle();
    resetn = 1'b0;
  endtask

  int tc_cnt;
  int exp_c3[5] = '{2, 1, 0, 0, 0};
  int exp_t3[5] = '{0, 0, 0, 1, 1};

  initial begin
    model_reset();
    resetn   = 1'b1;
    en       = '1;
    dir      = '1;
    sat      = '0;
    load     = '0;
    clr      = '0;
    load_val = '0;
    limit    = {8'hFF, 8'hFF};
`ifdef MCC_PRESCALE_EN
    psc_div  = '0;
`endif

    // Reset held with enables active
    for (int i = 0; i < 7; i++) begin
      cycle();
      check("rst_c_out", 32'(c_out), 0);
      check("rst_flags", 32'({tc, wrap_flg}), 0);
    end
    resetn = 1'b0;
    cycle();
    check("release_first_count", 32'(c_out[7:0]), 1);
    $display("scenario reset/release: c_out=%h", c_out);

    // ch0 full-range wrap
    en = '0; load = 2'b01; load_val = '0; clr = 2'b01; dir[0] = 1'b1; sat[0] = 1'b0;
    cycle();
    load = '0; clr = '0; en = 2'b01; tc_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      cycle();
      if (i == 254) check("t2_top", 32'(c_out[7:0]), 32'hFF);
      if (tc[0]) begin
        tc_cnt++;
        check("t2_tc_at_zero", 32'(c_out[7:0]), 0);
      end
    end
    check("t2_final", 32'(c_out[7:0]), 0);
    check("t2_tc_count", tc_cnt, 1);
    check("t2_wrap", 32'(wrap_flg[0]), 1);
    $display("scenario wrap256: tc pulses=%0d wrap_flg=%b", tc_cnt, wrap_flg);

    // ch1 saturating count-down
    en = '0; load = 2'b10; load_val[15:8] = 8'h03; sat[1] = 1'b1; dir[1] = 1'b0; clr = 2'b10;
    cycle();
    load = '0; clr = '0; en = 2'b10;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t3_cnt", 32'(c_out[15:8]), exp_c3[i]);
      check("t3_tc", 32'(tc[1]), exp_t3[i]);
    end
    check("t3_wrap", 32'(wrap_flg[1]), 0);
    $display("scenario sat_down: c1=%h wrap_flg=%b", c_out[15:8], wrap_flg);

    // ch0 modulus 10, then clamped load
    en = '0; load = 2'b01; load_val[7:0] = 8'h00; limit[7:0] = 8'd9;
    cycle();
    load = '0; en = 2'b01;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t4_cnt", 32'(c_out[7:0]), (i + 1) % 10);
      check("t4_tc", 32'(tc[0]), (i == 9) ? 1 : 0);
    end
    en = '0; load = 2'b01; load_val[7:0] = 8'h20;
    cycle();
    check("t4_clamp", 32'(c_out[7:0]), 9);
    check("t4_clamp_tc", 32'(tc[0]), 0);
    $display("scenario mod10: c0=%h", c_out[7:0]);

    // load beats enable; set beats clear
    load = 2'b11; en = 2'b01; load_val = {8'd9, 8'd5}; limit = {8'd9, 8'd9};
    sat[1] = 1'b0; dir[1] = 1'b1; clr = 2'b10;
    cycle();
    check("t5_load_wins", 32'(c_out[7:0]), 5);
    load = '0; en = 2'b10; clr = 2'b10;
    cycle();
    check("t5_wrap_cnt", 32'(c_out[15:8]), 0);
    check("t5_wrap_tc", 32'(tc[1]), 1);
    check("t5_set_wins", 32'(wrap_flg[1]), 1);
    en = '0;
    cycle();
    check("t5_clr", 32'(wrap_flg[1]), 0);
    $display("scenario load/clr priority: c_out=%h wrap_flg=%b", c_out, wrap_flg);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en   = NCH'($urandom);
      dir  = NCH'($urandom);
      sat  = NCH'($urandom);
      clr  = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      for (int c = 0; c < NCH; c++) begin
        load[c] = ($urandom_range(0, 15) == 0);
        load_val[c*CW +: CW] = CW'($urandom);
        if ($urandom_range(0, 31) == 0)
          limit[c*CW +: CW] = $urandom_range(0, 1) ? CW'($urandom_range(0, 5)) : CW'($urandom);
      end
`ifdef MCC_PRESCALE_EN
      if ($urandom_range(0, 63) == 0) psc_div = PSW'($urandom_range(0, 3));
`endif
      cycle();
    end
    $display("scenario random: %0d checks so far", n_checks);

    // Asynchronous reset mid-count
    load = 2'b11; load_val = {8'd7, 8'd7}; limit = {8'hFF, 8'hFF}; en = '0; clr = '0;
`ifdef MCC_PRESCALE_EN
    psc_div = '0;
`endif
    cycle();
    load = '0; en = 2'b11; dir = 2'b11; sat = '0;
    cycle();
    mid_reset("async_rst");
    $display("scenario async reset: c_out=%h", c_out);

`ifdef MCC_PRESCALE_EN
    // Prescaled counting, divide by 4
    resetn = 1'b1; psc_div = 8'd3; en = 2'b01; dir = 2'b11; sat = '0;
    cycle();
    resetn = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      check("t6_psc_cnt", 32'(c_out[7:0]), i / 4);
    end
    mid_reset("t6_rst");
    $display("scenario prescale: c0=%h", c_out[7:0]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
